// File: rtl/truth_table_probe.sv
// truth_table_probe: sweeps the four {x1,x0} input vectors through a
// two-input combinational block under test. After a programmable settle
// time it samples NUM_CH response lines for each vector. The completed
// 4-bit truth table of every channel is returned over a valid/ready
// handshake.
module truth_table_probe #(
  parameter int NUM_CH        = 18,
  parameter int SETTLE_CYCLES = 2    // legal range 0..15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  x0,
  output logic                  x1,
  input  logic [NUM_CH-1:0]     sense,
  output logic                  tt_valid,
  input  logic                  tt_ready,
  output logic [4*NUM_CH-1:0]   tt_data,
  output logic [NUM_CH-1:0]     const_mask
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Last settle count of a vector slot; each slot lasts SETTLE_CYCLES+1 cycles.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

  state_t              state;
  logic [1:0]          vec;
  logic [3:0]          settle;
  logic [4*NUM_CH-1:0] work;       // partially collected table
  logic [4*NUM_CH-1:0] captured;   // work with the current sense merged in
  logic [NUM_CH-1:0]   mask_next;
  logic                slot_end;

  // The current vector slot ends at the next edge.
  always_comb begin
    slot_end = (settle == SETTLE_LAST);
  end

  // Merge the live sense lines into bit 'vec' of every channel's nibble.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    captured = work;
    for (int i = 0; i < NUM_CH; i++) begin
      captured[4*i + int'(vec)] = sense[i];
    end
  end

  // A channel is constant when its completed table is all zeros or all ones.
  always_comb begin
    mask_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      mask_next[i] = (captured[4*i +: 4] == 4'h0) || (captured[4*i +: 4] == 4'hF);
    end
  end

  // Sweep sequencer: drives the vectors, captures the responses, and holds the result.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      // NOTE: the result and work registers are cleared as well, so no stale partial table survives a reset.
      state      <= IDLE;
      vec        <= 2'd0;
      settle     <= 4'd0;
      busy       <= 1'b0;
      x0         <= 1'b0;
      x1         <= 1'b0;
      tt_valid   <= 1'b0;
      tt_data    <= '0;
      const_mask <= '0;
      work       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= DRIVE;
            busy     <= 1'b1;
            vec      <= 2'd0;
            settle   <= 4'd0;
            {x1, x0} <= 2'd0;
            work     <= '0;
          end
        end

        DRIVE: begin
          if (slot_end) begin
            work   <= captured;
            settle <= 4'd0;
            if (vec == 2'd3) begin
              // The table is complete: present it and park the stimulus at 00.
              state      <= HOLD;
              busy       <= 1'b0;
              tt_valid   <= 1'b1;
              tt_data    <= captured;
              const_mask <= mask_next;
              {x1, x0}   <= 2'd0;
            end else begin
              vec      <= vec + 2'd1;
              {x1, x0} <= vec + 2'd1;
            end
          end else begin
            settle <= settle + 4'd1;
          end
        end

        HOLD: begin
          // start is deliberately ignored here, even in the handshake cycle.
          if (tt_ready) begin
            tt_valid <= 1'b0;
            state    <= IDLE;
          end
        end

        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          tt_valid <= 1'b0;
          {x1, x0} <= 2'd0;
        end
      endcase
    end
  end

endmodule
